// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller
//
// Issues one instruction-memory request at a time, holds the returned word for
// decode, and steers the fetch stream on taken branches/jumps from execute.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect target with redirect_pc[1:0]!=0 is word-aligned
//               before loading and misalign_exc pulses for one cycle.
//   undefined : redirect target loaded as-is, misalign_exc tied low.
//
// Ports
//   clock, reset            : rising-edge clock, async active-high reset
//   redirect_valid/_pc      : taken branch/jump and its target
//   stall                   : decode not ready, held instruction not consumed
//   if_req/if_addr          : fetch request and address to instruction memory
//   if_ack/if_rdata         : memory accept, instruction word valid with ack
//   inst_valid/inst/inst_pc : instruction held for decode and its address
//   misalign_exc            : one-cycle pulse for a misaligned redirect target
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_pc;       // address of the request in flight / next request
  logic [63:0] r_tgt;      // redirect target parked while a stale request drains
  logic [31:0] r_inst;
  logic [63:0] r_inst_pc;
  logic [63:0] w_redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_redir_pc = {redirect_pc[63:2], 2'b00};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_misalign <= 1'b0;
    else       r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

  assign misalign_exc = r_misalign;
`else
  assign w_redir_pc   = redirect_pc;
  assign misalign_exc = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; redirect outranks ack and stall everywhere
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ: begin
        if (redirect_valid) w_next = if_ack ? S_REQ : S_DROP;
        else if (if_ack)    w_next = S_OUT;
      end
      // The stale request must finish its handshake before the new address
      // goes out; a redirect coincident with that ack becomes the new pc.
      S_DROP: begin
        if (if_ack) w_next = S_REQ;
      end
      S_OUT: begin
        if (redirect_valid || !stall) w_next = S_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    if_req     = 1'b0;
    inst_valid = 1'b0;
    case (r_state)
      S_REQ, S_DROP: if_req     = 1'b1;
      S_OUT:         inst_valid = 1'b1;
      default: ;
    endcase
  end

  assign if_addr = r_pc;
  assign inst    = r_inst;
  assign inst_pc = r_inst_pc;

  // Datapath: pc, parked target, held instruction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_tgt     <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) r_pc <= w_redir_pc;
        end
        S_REQ: begin
          if (redirect_valid) begin
            // Keep if_addr steady mid-handshake; park the target instead.
            if (if_ack) r_pc  <= w_redir_pc;
            else        r_tgt <= w_redir_pc;
          end else if (if_ack) begin
            r_inst    <= if_rdata;
            r_inst_pc <= r_pc;
          end
        end
        S_DROP: begin
          if (redirect_valid) begin
            if (if_ack) r_pc  <= w_redir_pc;
            else        r_tgt <= w_redir_pc;
          end else if (if_ack) begin
            r_pc <= r_tgt;
          end
        end
        S_OUT: begin
          if (redirect_valid) r_pc <= w_redir_pc;
          else if (!stall)    r_pc <= r_pc + 64'd4;  // wraps modulo 2^64
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl
//   Directed per-cycle vector table, short hand-written reset/IDLE sequences,
//   and a randomised memory/decode stream checked through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack = 1'b0;
  logic [31:0] if_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign_exc;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .misalign_exc(misalign_exc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        st;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_val;
    logic [31:0] e_inst;
    logic [63:0] e_ipc;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } sb_t;

  vec_t tv[$];
  sb_t  sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [63:0] rpc, input logic st,
                       input logic ack, input logic [31:0] rd);
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    if_ack         = ack;
    if_rdata       = rd;
  endtask

  function automatic vec_t mk(logic rv, logic [63:0] rpc, logic st, logic ack,
                              logic [31:0] rd, logic e_req, logic [63:0] e_addr,
                              logic e_val, logic [31:0] e_inst, logic [63:0] e_ipc,
                              logic e_mis);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.st = st; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] hash(logic [63:0] pc);
    return pc[31:0] ^ 32'hA5A5_0F0F;
  endfunction

  logic [63:0] ta6;

  initial begin
    ta6 = MIS ? 64'h8000_0004 : 64'h8000_0006;

    // cycle-by-cycle table: inputs for this cycle, outputs expected before the edge
    //             rv  rpc                    st ack rd              req addr                 val inst            ipc                    mis
    tv.push_back(mk(0, 0,                     0, 0, 0,              0, 64'h8000_0000,         0, 0,              0,                     0)); // IDLE
    tv.push_back(mk(0, 0,                     0, 0, 0,              1, 64'h8000_0000,         0, 0,              0,                     0));
    tv.push_back(mk(0, 0,                     0, 1, 32'hA000_0000,  1, 64'h8000_0000,         0, 0,              0,                     0));
    tv.push_back(mk(0, 0,                     0, 0, 0,              0, 64'h8000_0000,         1, 32'hA000_0000,  64'h8000_0000,         0));
    tv.push_back(mk(0, 0,                     0, 0, 0,              1, 64'h8000_0004,         0, 32'hA000_0000,  64'h8000_0000,         0));
    tv.push_back(mk(0, 0,                     0, 1, 32'hA000_0001,  1, 64'h8000_0004,         0, 32'hA000_0000,  64'h8000_0000,         0));
    tv.push_back(mk(0, 0,                     1, 0, 0,              0, 64'h8000_0004,         1, 32'hA000_0001,  64'h8000_0004,         0)); // stall x3
    tv.push_back(mk(0, 0,                     1, 0, 0,              0, 64'h8000_0004,         1, 32'hA000_0001,  64'h8000_0004,         0));
    tv.push_back(mk(0, 0,                     1, 0, 0,              0, 64'h8000_0004,         1, 32'hA000_0001,  64'h8000_0004,         0));
    tv.push_back(mk(0, 0,                     0, 0, 0,              0, 64'h8000_0004,         1, 32'hA000_0001,  64'h8000_0004,         0));
    tv.push_back(mk(0, 0,                     0, 1, 32'hA000_0002,  1, 64'h8000_0008,         0, 32'hA000_0001,  64'h8000_0004,         0)); // first-cycle ack
    tv.push_back(mk(0, 0,                     0, 0, 0,              0, 64'h8000_0008,         1, 32'hA000_0002,  64'h8000_0008,         0));
    tv.push_back(mk(1, 64'h8000_1000,         0, 0, 0,              1, 64'h8000_000C,         0, 32'hA000_0002,  64'h8000_0008,         0)); // redirect in REQ
    tv.push_back(mk(0, 0,                     0, 0, 0,              1, 64'h8000_000C,         0, 32'hA000_0002,  64'h8000_0008,         0)); // DROP, old addr
    tv.push_back(mk(0, 0,                     0, 1, 32'hDEAD_0000,  1, 64'h8000_000C,         0, 32'hA000_0002,  64'h8000_0008,         0));
    tv.push_back(mk(1, 64'h8000_2000,         0, 1, 32'hB000_0000,  1, 64'h8000_1000,         0, 32'hA000_0002,  64'h8000_0008,         0)); // redirect+ack
    tv.push_back(mk(0, 0,                     0, 1, 32'hB000_0001,  1, 64'h8000_2000,         0, 32'hA000_0002,  64'h8000_0008,         0));
    tv.push_back(mk(1, 64'h8000_3000,         1, 0, 0,              0, 64'h8000_2000,         1, 32'hB000_0001,  64'h8000_2000,         0)); // OUT&stall&redirect
    tv.push_back(mk(1, 64'h8000_0006,         0, 0, 0,              1, 64'h8000_3000,         0, 32'hB000_0001,  64'h8000_2000,         0));
    tv.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFC,0, 0, 0,             1, 64'h8000_3000,         0, 32'hB000_0001,  64'h8000_2000,         MIS)); // overwrite target
    tv.push_back(mk(0, 0,                     0, 1, 32'hDEAD_0001,  1, 64'h8000_3000,         0, 32'hB000_0001,  64'h8000_2000,         0));
    tv.push_back(mk(0, 0,                     0, 1, 32'hC000_0000,  1, 64'hFFFF_FFFF_FFFF_FFFC,0, 32'hB000_0001,  64'h8000_2000,         0));
    tv.push_back(mk(0, 0,                     0, 0, 0,              0, 64'hFFFF_FFFF_FFFF_FFFC,1, 32'hC000_0000,  64'hFFFF_FFFF_FFFF_FFFC,0));
    tv.push_back(mk(0, 0,                     0, 1, 32'hC000_0001,  1, 64'h0,                  0, 32'hC000_0000,  64'hFFFF_FFFF_FFFF_FFFC,0)); // wrap
    tv.push_back(mk(1, 64'h8000_0006,         0, 0, 0,              0, 64'h0,                  1, 32'hC000_0001,  64'h0,                 0));
    tv.push_back(mk(0, 0,                     0, 0, 0,              1, ta6,                    0, 32'hC000_0001,  64'h0,                 MIS));
    tv.push_back(mk(0, 0,                     0, 0, 0,              1, ta6,                    0, 32'hC000_0001,  64'h0,                 0));

    // reset values while reset is held
    reset = 1'b1;
    tick();
    chk("rst_if_req",     {63'd0, if_req},       64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid},   64'd0);
    chk("rst_inst",       {32'd0, inst},         64'd0);
    chk("rst_inst_pc",    inst_pc,               64'd0);
    chk("rst_if_addr",    if_addr,               RST_PC);
    chk("rst_misalign",   {63'd0, misalign_exc}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      string n;
      n = $sformatf("v%0d", i);
      chk({n, "_if_req"},     {63'd0, if_req},       {63'd0, tv[i].e_req});
      chk({n, "_if_addr"},    if_addr,               tv[i].e_addr);
      chk({n, "_inst_valid"}, {63'd0, inst_valid},   {63'd0, tv[i].e_val});
      chk({n, "_inst"},       {32'd0, inst},         {32'd0, tv[i].e_inst});
      chk({n, "_inst_pc"},    inst_pc,               tv[i].e_ipc);
      chk({n, "_misalign"},   {63'd0, misalign_exc}, {63'd0, tv[i].e_mis});
      drive(tv[i].rv, tv[i].rpc, tv[i].st, tv[i].ack, tv[i].rd);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0);

    // reset mid-request, then a late ack arriving in IDLE is ignored
    do_reset();
    tick();                                   // now in REQ
    chk("mid_req_before", {63'd0, if_req}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", {63'd0, if_req}, 64'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1, 32'h1234_5678); // stale ack in IDLE
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("late_ack_val",  {63'd0, inst_valid}, 64'd0);
    chk("late_ack_req",  {63'd0, if_req},     64'd1);
    chk("late_ack_addr", if_addr,             RST_PC);
    chk("late_ack_inst", {32'd0, inst},       64'd0);

    // redirect while in IDLE loads pc before the first request
    do_reset();
    drive(1'b1, 64'h8000_4000, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("idle_redir_req",  {63'd0, if_req}, 64'd1);
    chk("idle_redir_addr", if_addr,         64'h8000_4000);

    // randomised stream: variable ack latency and stall, scoreboard on consume
    begin
      logic [63:0] e_pc;
      int          consumed;
      int          cyc;
      do_reset();
      e_pc     = RST_PC;
      consumed = 0;
      cyc      = 0;
      sbq.delete();
      while (consumed < 24 && cyc < 3000) begin
        logic ack, st;
        ack = 1'b0;
        st  = 1'b0;
        if (if_req) begin
          chk("sb_if_addr", if_addr, e_pc);
          ack = ($urandom_range(0, 2) == 0);
          if (ack) sbq.push_back('{pc: e_pc, data: hash(e_pc)});
        end
        if (inst_valid) begin
          st = ($urandom_range(0, 2) == 0);
          if (!st) begin
            if (sbq.size() == 0) begin
              chk("sb_underflow", 64'd1, 64'd0);
            end else begin
              sb_t s;
              s = sbq.pop_front();
              chk("sb_inst",    {32'd0, inst}, {32'd0, s.data});
              chk("sb_inst_pc", inst_pc,       s.pc);
            end
            e_pc = e_pc + 64'd4;
            consumed++;
          end
        end
        drive(1'b0, '0, st, ack, ack ? hash(if_addr) : 32'h0);
        tick();
        cyc++;
      end
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      chk("sb_consumed", 64'(consumed), 64'd24);
      chk("sb_leftover", 64'(sbq.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
